// File: rtl/button_debouncer.sv
// Debounces a raw push-button: synchroniser, then a four-state qualification FSM with a
// stability counter; emits a clean level plus one-cycle rise/fall strobes.
module button_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
);

  // state     | meaning
  // IDLE_LOW  | level settled at 0
  // WAIT_HIGH | s=1 seen, counting stable high samples
  // IDLE_HIGH | level settled at 1
  // WAIT_LOW  | s=0 seen, counting stable low samples
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b10,
    WAIT_LOW  = 2'b11
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobes are computed alongside the completing transition so they land with the level change
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    busy    = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);
    case (state_q)
      IDLE_LOW:  level_d = 1'b0;
      IDLE_HIGH: level_d = 1'b1;
      WAIT_HIGH: begin
        if (s && cnt_q == CNT_LAST) begin
          level_d = 1'b1;
          rise_d  = 1'b1;
        end
      end
      WAIT_LOW: begin
        if (!s && cnt_q == CNT_LAST) begin
          level_d = 1'b0;
          fall_d  = 1'b1;
        end
      end
      default: level_d = 1'b0;
    endcase
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer at default parameters; edges are counted from the
// first posedge that samples a new btn_raw value.
module tb_button_debouncer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_raw = 1'b0;
  logic level, rise, fall, busy;

  int tests = 0;
  int fails = 0;

  button_debouncer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_raw),
    .level   (level),
    .rise    (rise),
    .fall    (fall),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int edge_n, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s edge %0d: observed %b expected %b", tag, edge_n, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e, input logic l, input logic r,
                         input logic f, input logic b);
    chk({tag, ".level"}, e, level, l);
    chk({tag, ".rise"},  e, rise,  r);
    chk({tag, ".fall"},  e, fall,  f);
    chk({tag, ".busy"},  e, busy,  b);
  endtask

  initial begin
    logic bseq [6];
    bseq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    // 1: reset held 3 cycles with btn_raw high
    rst_n   = 1'b0;
    btn_raw = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      chk_all("reset", e, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    btn_raw = 1'b0;
    step();
    rst_n = 1'b1;
    for (int e = 0; e < 4; e++) step();

    // 2: clean rising step
    btn_raw = 1'b1;
    for (int e = 1; e <= 19; e++) begin
      step();
      chk_all("step_up", e, e >= 18, e == 18, 1'b0, (e >= 3) && (e <= 17));
    end

    // 5: clean falling step from level=1
    btn_raw = 1'b0;
    for (int e = 1; e <= 19; e++) begin
      step();
      chk_all("step_dn", e, e < 18, 1'b0, e == 18, (e >= 3) && (e <= 17));
    end

    // 3: 10-cycle high pulse is rejected
    btn_raw = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      step();
      if (e == 10) btn_raw = 1'b0;
      chk_all("short", e, 1'b0, 1'b0, 1'b0, (e >= 3) && (e <= 12));
    end

    // 4: bounce 1,0,1,1,0,1 then held high; qualification restarts after the last 0
    for (int e = 1; e <= 25; e++) begin
      btn_raw = (e <= 6) ? bseq[e-1] : 1'b1;
      step();
      chk({"bounce", ".level"}, e, level, e >= 23);
      chk({"bounce", ".rise"},  e, rise,  e == 23);
      chk({"bounce", ".fall"},  e, fall,  1'b0);
    end

    // return to low cleanly
    btn_raw = 1'b0;
    for (int e = 0; e < 20; e++) step();
    chk("pre6.level", 0, level, 1'b0);

    // 6: reset in the middle of qualification (cnt=8)
    btn_raw = 1'b1;
    for (int e = 1; e <= 10; e++) step();
    chk("mid.busy", 10, busy, 1'b1);
    tests++;
    assert (dut.cnt_q === 5'd8) else begin
      fails++;
      $error("FAIL mid.cnt edge 10: observed %0d expected 8", dut.cnt_q);
    end
    rst_n = 1'b0;
    step();
    chk_all("rst_mid", 11, 1'b0, 1'b0, 1'b0, 1'b0);
    tests++;
    assert (dut.cnt_q === 5'd0) else begin
      fails++;
      $error("FAIL rst_mid.cnt: observed %0d expected 0", dut.cnt_q);
    end
    tests++;
    assert (dut.state_q === 2'b00) else begin
      fails++;
      $error("FAIL rst_mid.state: observed %b expected 00", dut.state_q);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 19; e++) begin
      step();
      chk_all("post_rst", e, e >= 18, e == 18, 1'b0, (e >= 3) && (e <= 17));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
